serial_add_ctrl: RTL and testbench
==================================

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits (legal range 2..32).
REQ-002 SHALL have port clk_i, input, 1, the single clock; all flops on rising edge.
REQ-003 SHALL have port rst_n_i, input, 1, reset, asynchronous, active-low.
REQ-004 SHALL have port start_i, input, 1, request a new addition; sampled only in IDLE.
REQ-005 SHALL have port abort_i, input, 1, synchronous cancel of an operation in progress.
REQ-006 SHALL have port a_i, input, WIDTH, operand A; captured on accepted start.
REQ-007 SHALL have port b_i, input, WIDTH, operand B; captured on accepted start.
REQ-008 SHALL have port sub_i, input, 1, 1 = A-B, 0 = A+B; present only when SERIAL_ADD_SUB_EN is defined.
REQ-009 SHALL have port ready_o, output, 1, high in IDLE and DONE (start will be accepted).
REQ-010 SHALL have port busy_o, output, 1, high in RUN.
REQ-011 SHALL have port done_o, output, 1, one-cycle pulse when the result becomes valid.
REQ-012 SHALL have port sum_o, output, WIDTH, result; holds until the next accepted start.
REQ-013 SHALL have port cout_o, output, 1, final carry out of the MSB slice.
REQ-014 SHALL have port ovf_o, output, 1, signed overflow (carry into MSB XOR carry out of MSB).

Function
REQ-015 SHALL compute the result bit-serially, LSB first, through one 1-bit full-adder slice, one bit per clock.
REQ-016 SHALL implement FSM states IDLE, RUN, DONE; IDLE->RUN on start_i; RUN->DONE after exactly WIDTH RUN cycles; DONE->RUN on start_i, else DONE->IDLE.
REQ-017 SHALL, on accepted start, load A and B into shift registers, clear the bit counter, and load the carry flop with 0 (add) or 1 (subtract).
REQ-018 SHALL, each RUN cycle, feed A[0], B[0] (B[0] inverted when subtracting) and the carry flop to the slice, shift the slice sum into sum MSB, shift A/B right, store slice carry.
REQ-019 SHALL give latency: start accepted in cycle 0, done_o high in cycle WIDTH+1, sum_o/cout_o/ovf_o valid from that cycle.
REQ-020 SHALL ignore start_i while busy_o is high; operands are not re-captured.
REQ-021 SHALL, on abort_i in RUN, go to IDLE next cycle with no done_o pulse; sum_o, cout_o and ovf_o SHALL be 0.
REQ-022 SHALL give abort_i priority over start_i in the same cycle; abort_i in IDLE/DONE SHALL have no effect other than blocking that cycle's start.
REQ-023 SHALL wrap arithmetic modulo 2^WIDTH; cout_o reports the carry out, ovf_o the signed overflow.
REQ-024 SHALL let the bit counter reach WIDTH-1 without wrap; counter width is clog2(WIDTH).

Reset
REQ-025 SHALL, on rst_n_i low, immediately force state IDLE, ready_o=1, busy_o=0, done_o=0, sum_o=0, cout_o=0, ovf_o=0, counter/shift/carry flops 0.
REQ-026 SHALL abandon any operation in progress when reset is asserted mid-RUN; no done_o after release.

Configuration
REQ-027 SHALL, with SERIAL_ADD_SUB_EN defined, provide sub_i and two's-complement subtraction (B inverted, carry-in 1).
REQ-028 SHALL, without SERIAL_ADD_SUB_EN, omit sub_i, always add with carry-in 0, and contain no inversion logic.

Structure
REQ-029 SHALL place the state enum (IDLE, RUN, DONE) and the default WIDTH constant in shared package serial_add_pkg.
REQ-030 SHALL instantiate exactly one sub-module, fa_bit_slice (1-bit full adder: a, b, carry in -> sum, carry out); the controller holds all sequential logic.

Verification
REQ-031 SHALL check, WIDTH=8: A=0x3C, B=0x15, add -> done_o in cycle 9, sum_o=0x51, cout_o=0, ovf_o=0.
REQ-032 SHALL check: A=0xFF, B=0x01, add -> sum_o=0x00, cout_o=1, ovf_o=0; A=0x7F, B=0x01 -> sum_o=0x80, ovf_o=1.
REQ-033 SHALL check, macro on: A=0x05, B=0x07, sub_i=1 -> sum_o=0xFE, cout_o=0; A=0x80, B=0x01 -> sum_o=0x7F, ovf_o=1.
REQ-034 SHALL check: start with A=0x10, B=0x20; start_i held high with A=0xAA in cycles 1-8 -> result 0x30, single done_o pulse; with start_i still high in DONE (cycle 9), new operation A=0xAA accepted and RUN begins in cycle 10.
REQ-035 SHALL check: abort_i in cycle 4 of RUN -> IDLE in cycle 5, no done_o, sum_o=0; abort_i and start_i together in IDLE -> no start.
REQ-036 SHALL check: rst_n_i low in cycle 3 of RUN -> all outputs at reset values without a clock edge; no done_o after release.

Source files
------------

// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM state
// encoding, default operand width and a counter-width helper.
package serial_add_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of a counter that must reach w-1; never narrower than one bit.
  function automatic int cntWidth(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Handshake and operand/result bundle for serial_add_ctrl.
// sub_i exists only when SERIAL_ADD_SUB_EN is defined.
interface serial_add_ctrl_if
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             start_i;
  logic             abort_i;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
`ifdef SERIAL_ADD_SUB_EN
  logic             sub_i;
`endif
  logic             ready_o;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] sum_o;
  logic             cout_o;
  logic             ovf_o;

  // Requester side: issues operations and observes the result.
  modport master (
    output start_i, abort_i, a_i, b_i,
`ifdef SERIAL_ADD_SUB_EN
    output sub_i,
`endif
    input  ready_o, busy_o, done_o, sum_o, cout_o, ovf_o
  );

  // Adder side: accepts operations and presents the result.
  modport slave (
    input  start_i, abort_i, a_i, b_i,
`ifdef SERIAL_ADD_SUB_EN
    input  sub_i,
`endif
    output ready_o, busy_o, done_o, sum_o, cout_o, ovf_o
  );

endinterface

// File: rtl/fa_bit_slice.sv
// One-bit full adder slice used by the serial adder datapath.
// Purely combinational; the controller owns all state.
module fa_bit_slice (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: adds (optionally subtracts) two WIDTH-bit
// operands LSB first through a single full-adder slice, one bit per clock.
// Optional feature macro: SERIAL_ADD_SUB_EN adds sub_i and A-B support.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic              clk_i,
  input logic              rst_n_i,
  serial_add_ctrl_if.slave bus
);

  localparam int CW = cntWidth(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] aShift_q, aShift_d;
  logic [WIDTH-1:0] bShift_q, bShift_d;
  logic [WIDTH-1:0] sumShift_q, sumShift_d;
  logic [CW-1:0]    count_q, count_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic             sliceB;
  logic             sliceSum;
  logic             sliceCarry;
  logic             startOk;
  logic             carryInit;

`ifdef SERIAL_ADD_SUB_EN
  logic             subMode_q, subMode_d;

  // Subtraction feeds the inverted B bit and seeds the carry with 1.
  assign sliceB    = bShift_q[0] ^ subMode_q;
  assign carryInit = bus.sub_i;
`else
  assign sliceB    = bShift_q[0];
  assign carryInit = 1'b0;
`endif

  // Abort wins over start whenever both arrive together.
  assign startOk = bus.start_i & ~bus.abort_i;

  fa_bit_slice u_slice (
    .a_i (aShift_q[0]),
    .b_i (sliceB),
    .c_i (carry_q),
    .s_o (sliceSum),
    .c_o (sliceCarry)
  );

  // State and datapath registers; reset clears everything immediately.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      aShift_q   <= '0;
      bShift_q   <= '0;
      sumShift_q <= '0;
      count_q    <= '0;
      carry_q    <= 1'b0;
      cout_q     <= 1'b0;
      ovf_q      <= 1'b0;
`ifdef SERIAL_ADD_SUB_EN
      subMode_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      aShift_q   <= aShift_d;
      bShift_q   <= bShift_d;
      sumShift_q <= sumShift_d;
      count_q    <= count_d;
      carry_q    <= carry_d;
      cout_q     <= cout_d;
      ovf_q      <= ovf_d;
`ifdef SERIAL_ADD_SUB_EN
      subMode_q  <= subMode_d;
`endif
    end
  end

  // Next-state logic: load on start, shift one bit per RUN cycle, flush on abort.
  always_comb begin
    state_d    = state_q;
    aShift_d   = aShift_q;
    bShift_d   = bShift_q;
    sumShift_d = sumShift_q;
    count_d    = count_q;
    carry_d    = carry_q;
    cout_d     = cout_q;
    ovf_d      = ovf_q;
`ifdef SERIAL_ADD_SUB_EN
    subMode_d  = subMode_q;
`endif

    case (state_q)
      IDLE, DONE: begin
        if (startOk) begin
          state_d    = RUN;
          aShift_d   = bus.a_i;
          bShift_d   = bus.b_i;
          sumShift_d = '0;
          count_d    = '0;
          carry_d    = carryInit;
          cout_d     = 1'b0;
          ovf_d      = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
          subMode_d  = bus.sub_i;
`endif
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end

      RUN: begin
        if (bus.abort_i) begin
          state_d    = IDLE;
          aShift_d   = '0;
          bShift_d   = '0;
          sumShift_d = '0;
          count_d    = '0;
          carry_d    = 1'b0;
          cout_d     = 1'b0;
          ovf_d      = 1'b0;
        end else begin
          sumShift_d = {sliceSum, sumShift_q[WIDTH-1:1]};
          aShift_d   = aShift_q >> 1;
          bShift_d   = bShift_q >> 1;
          carry_d    = sliceCarry;
          if (count_q == LAST_BIT) begin
            state_d = DONE;
            cout_d  = sliceCarry;
            ovf_d   = sliceCarry ^ carry_q;
          end else begin
            count_d = count_q + CW'(1);
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.ready_o = (state_q == IDLE) || (state_q == DONE);
  assign bus.busy_o  = (state_q == RUN);
  assign bus.done_o  = (state_q == DONE);
  assign bus.sum_o   = sumShift_q;
  assign bus.cout_o  = cout_q;
  assign bus.ovf_o   = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed testbench for serial_add_ctrl (WIDTH=8).
// Subtraction vectors run only when SERIAL_ADD_SUB_EN is defined.
module tb_serial_add_ctrl;

  logic clk;
  logic rst_n;
  int   checkCount;
  int   errorCount;

  serial_add_ctrl_if #(.WIDTH(8)) bus ();

  serial_add_ctrl #(.WIDTH(8)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Launches one operation at the current negedge (cycle 0) and waits for done_o.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                               output int latency);
    bit found;
    found        = 1'b0;
    latency      = 0;
    bus.start_i  = 1'b1;
    bus.a_i      = a;
    bus.b_i      = b;
    for (int k = 1; k <= 40 && !found; k++) begin
      @(negedge clk);
      if (k == 1) begin
        bus.start_i = 1'b0;
        checkOutput("busy in cycle 1", bus.busy_o, 1'b1);
      end
      if (bus.done_o) begin
        latency = k;
        found   = 1'b1;
      end
    end
  endtask

  // Runs one operation and checks latency, result flags and the single done pulse.
  task automatic runOp(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] expSum, input logic expCout,
                       input logic expOvf);
    int lat;
    applyStimulus(a, b, lat);
    checkOutput({tag, " latency"}, lat, 9);
    checkOutput({tag, " sum"}, bus.sum_o, expSum);
    checkOutput({tag, " cout"}, bus.cout_o, expCout);
    checkOutput({tag, " ovf"}, bus.ovf_o, expOvf);
    @(negedge clk);
    checkOutput({tag, " done single"}, bus.done_o, 1'b0);
    checkOutput({tag, " ready after"}, bus.ready_o, 1'b1);
    checkOutput({tag, " sum holds"}, bus.sum_o, expSum);
  endtask

  // Abandon the run if the design never finishes.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed test sequence.
  initial begin
    int doneCount;
    int lat;
    bit found;

    checkCount  = 0;
    errorCount  = 0;
    rst_n       = 1'b0;
    bus.start_i = 1'b0;
    bus.abort_i = 1'b0;
    bus.a_i     = '0;
    bus.b_i     = '0;
`ifdef SERIAL_ADD_SUB_EN
    bus.sub_i   = 1'b0;
`endif

    #2;
    checkOutput("reset ready", bus.ready_o, 1'b1);
    checkOutput("reset busy", bus.busy_o, 1'b0);
    checkOutput("reset done", bus.done_o, 1'b0);
    checkOutput("reset sum", bus.sum_o, 8'h00);
    checkOutput("reset cout", bus.cout_o, 1'b0);
    checkOutput("reset ovf", bus.ovf_o, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] additions");
    runOp("add 3C+15", 8'h3C, 8'h15, 8'h51, 1'b0, 1'b0);
    runOp("add FF+01", 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);
    runOp("add 7F+01", 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1);
    runOp("add A5+5A", 8'hA5, 8'h5A, 8'hFF, 1'b0, 1'b0);
    runOp("add 80+80", 8'h80, 8'h80, 8'h00, 1'b1, 1'b1);

`ifdef SERIAL_ADD_SUB_EN
    $display("[TB] subtractions");
    bus.sub_i = 1'b1;
    runOp("sub 05-07", 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0);
    runOp("sub 80-01", 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1);
    bus.sub_i = 1'b0;
`endif

    $display("[TB] start held through run");
    doneCount   = 0;
    bus.start_i = 1'b1;
    bus.a_i     = 8'h10;
    bus.b_i     = 8'h20;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (k == 1) bus.a_i = 8'hAA;
      if (bus.done_o) doneCount++;
      if (k == 9) begin
        checkOutput("held done cycle 9", bus.done_o, 1'b1);
        checkOutput("held sum", bus.sum_o, 8'h30);
      end
    end
    checkOutput("held done pulses", doneCount, 1);
    @(negedge clk);
    checkOutput("held rerun busy cycle 10", bus.busy_o, 1'b1);
    checkOutput("held rerun done low", bus.done_o, 1'b0);
    bus.start_i = 1'b0;
    lat   = 0;
    found = 1'b0;
    for (int k = 1; k <= 40 && !found; k++) begin
      @(negedge clk);
      if (bus.done_o) begin
        lat   = k;
        found = 1'b1;
      end
    end
    checkOutput("held rerun latency", lat, 8);
    checkOutput("held rerun sum", bus.sum_o, 8'hCA);
    @(negedge clk);

    $display("[TB] abort during run");
    bus.start_i = 1'b1;
    bus.a_i     = 8'h12;
    bus.b_i     = 8'h34;
    doneCount   = 0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      bus.start_i = 1'b0;
      if (bus.done_o) doneCount++;
    end
    bus.abort_i = 1'b1;
    @(negedge clk);
    bus.abort_i = 1'b0;
    checkOutput("abort ready", bus.ready_o, 1'b1);
    checkOutput("abort busy", bus.busy_o, 1'b0);
    checkOutput("abort sum", bus.sum_o, 8'h00);
    checkOutput("abort cout", bus.cout_o, 1'b0);
    checkOutput("abort ovf", bus.ovf_o, 1'b0);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.done_o) doneCount++;
    end
    checkOutput("abort no done", doneCount, 0);

    $display("[TB] abort with start in idle");
    bus.start_i = 1'b1;
    bus.abort_i = 1'b1;
    bus.a_i     = 8'h01;
    bus.b_i     = 8'h01;
    @(negedge clk);
    bus.start_i = 1'b0;
    bus.abort_i = 1'b0;
    checkOutput("abort+start busy", bus.busy_o, 1'b0);
    checkOutput("abort+start ready", bus.ready_o, 1'b1);
    doneCount = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.done_o) doneCount++;
    end
    checkOutput("abort+start no done", doneCount, 0);

    $display("[TB] reset during run");
    bus.start_i = 1'b1;
    bus.a_i     = 8'hFF;
    bus.b_i     = 8'hFF;
    @(negedge clk);
    bus.start_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midreset ready", bus.ready_o, 1'b1);
    checkOutput("midreset busy", bus.busy_o, 1'b0);
    checkOutput("midreset done", bus.done_o, 1'b0);
    checkOutput("midreset sum", bus.sum_o, 8'h00);
    checkOutput("midreset cout", bus.cout_o, 1'b0);
    checkOutput("midreset ovf", bus.ovf_o, 1'b0);
    @(negedge clk);
    rst_n     = 1'b1;
    doneCount = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (bus.done_o) doneCount++;
    end
    checkOutput("midreset no done", doneCount, 0);
    checkOutput("midreset idle ready", bus.ready_o, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
